uart_top: RTL and testbench

UART_TOP -- requirements
Module: uart_top

---
 rtl/uart_top.sv | 156 +++++++++++++++
 tb/tb_uart_top.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_top.sv
// uart_top: 8N1 UART (no parity) with independent transmit and receive paths.
// Each path runs from its own free-running baud counter and changes state only on that counter's tick.
module uart_top #(
   parameter int clk_freq  = 1_000_000,
   parameter int baud_rate = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic [7:0] dintx,
   input  logic       newd,
   output logic       tx,
   output logic [7:0] doutrx,
   output logic       donetx,
   output logic       donerx
);

   localparam int CLKS_RAW     = clk_freq / baud_rate;
   localparam int CLKS_PER_BIT = (CLKS_RAW > 0) ? CLKS_RAW : 1;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_e;
   typedef enum logic {RX_IDLE, RX_DATA} rxState_e;

   logic [CNT_W-1:0] txCnt_q;
   logic [CNT_W-1:0] rxCnt_q;
   logic             txTick;
   logic             rxTick;

   txState_e         txState_q, txState_d;
   logic [7:0]       txShreg_q, txShreg_d;
   logic [2:0]       txBitIdx_q, txBitIdx_d;

   rxState_e         rxState_q, rxState_d;
   logic [7:0]       rxShreg_q, rxShreg_d;
   logic [2:0]       rxBitCnt_q, rxBitCnt_d;
   logic [7:0]       doutrx_q, doutrx_d;
   logic             donerx_q, donerx_d;

   assign txTick = (txCnt_q == CNT_LAST);
   assign rxTick = (rxCnt_q == CNT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         txCnt_q <= '0;
         rxCnt_q <= '0;
      end else begin
         txCnt_q <= txTick ? '0 : txCnt_q + CNT_W'(1);
         rxCnt_q <= rxTick ? '0 : rxCnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         txState_q  <= TX_IDLE;
         txShreg_q  <= '0;
         txBitIdx_q <= '0;
      end else begin
         txState_q  <= txState_d;
         txShreg_q  <= txShreg_d;
         txBitIdx_q <= txBitIdx_d;
      end
   end

   // The byte is captured only at the IDLE->START tick, so later dintx changes cannot corrupt a frame.
   always_comb begin
      txState_d  = txState_q;
      txShreg_d  = txShreg_q;
      txBitIdx_d = txBitIdx_q;
      if (txTick) begin
         case (txState_q)
            TX_IDLE: begin
               if (newd) begin
                  txShreg_d = dintx;
                  txState_d = TX_START;
               end
            end
            TX_START: begin
               txBitIdx_d = '0;
               txState_d  = TX_DATA;
            end
            TX_DATA: begin
               txBitIdx_d = txBitIdx_q + 3'd1;
               if (txBitIdx_q == 3'd7) begin
                  txState_d = TX_STOP;
               end
            end
            TX_STOP: txState_d = TX_IDLE;
            default: txState_d = TX_IDLE;
         endcase
      end
   end

   always_comb begin
      tx     = 1'b1;
      donetx = 1'b0;
      case (txState_q)
         TX_START: tx = 1'b0;
         TX_DATA:  tx = txShreg_q[txBitIdx_q];
         TX_STOP:  donetx = txTick;
         default:  tx = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rxState_q  <= RX_IDLE;
         rxShreg_q  <= '0;
         rxBitCnt_q <= '0;
         doutrx_q   <= '0;
         donerx_q   <= 1'b0;
      end else begin
         rxState_q  <= rxState_d;
         rxShreg_q  <= rxShreg_d;
         rxBitCnt_q <= rxBitCnt_d;
         doutrx_q   <= doutrx_d;
         donerx_q   <= donerx_d;
      end
   end

   // Stop bit is never checked: a low line at the next idle tick is simply a new start bit.
   always_comb begin
      rxState_d  = rxState_q;
      rxShreg_d  = rxShreg_q;
      rxBitCnt_d = rxBitCnt_q;
      doutrx_d   = doutrx_q;
      donerx_d   = 1'b0;
      if (rxTick) begin
         case (rxState_q)
            RX_IDLE: begin
               if (!rx) begin
                  rxBitCnt_d = '0;
                  rxState_d  = RX_DATA;
               end
            end
            RX_DATA: begin
               rxShreg_d  = {rx, rxShreg_q[7:1]};
               rxBitCnt_d = rxBitCnt_q + 3'd1;
               if (rxBitCnt_q == 3'd7) begin
                  doutrx_d  = {rx, rxShreg_q[7:1]};
                  donerx_d  = 1'b1;
                  rxState_d = RX_IDLE;
               end
            end
            default: rxState_d = RX_IDLE;
         endcase
      end
   end

   always_comb begin
      doutrx = doutrx_q;
      donerx = donerx_q;
   end

endmodule

// File: tb/tb_uart_top.sv
// tb_uart_top: directed and random checks of uart_top framing, timing, back-to-back traffic and reset abort.
// Expected waveforms come from bit-period arithmetic measured from reset release, not from the design's internals.
module tb_uart_top;

   localparam int CLK_FREQ = 1_000_000;
   localparam int BAUD     = 9600;
   localparam int CPB      = CLK_FREQ / BAUD;

   logic       clk   = 1'b0;
   logic       rst   = 1'b0;
   logic       rx    = 1'b1;
   logic [7:0] dintx = 8'h00;
   logic       newd  = 1'b0;
   logic       tx;
   logic [7:0] doutrx;
   logic       donetx;
   logic       donerx;

   int         nAsserts    = 0;
   int         nFail       = 0;
   int         clkSinceRst = 0;
   logic       rxSyms[$];
   logic [7:0] rxGot[$];

   uart_top #(
      .clk_freq  (CLK_FREQ),
      .baud_rate (BAUD)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .rx     (rx),
      .dintx  (dintx),
      .newd   (newd),
      .tx     (tx),
      .doutrx (doutrx),
      .donetx (donetx),
      .donerx (donerx)
   );

   always #5 clk = ~clk;

   // Clocks since reset release; ticks land on edges where this is a multiple of CPB.
   always @(posedge clk or negedge rst) begin
      if (!rst) clkSinceRst <= 0;
      else      clkSinceRst <= clkSinceRst + 1;
   end

   task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nAsserts++;
      assert (observed === expected)
      else begin
         nFail++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Ideal line level after edge r for a frame whose byte is latched at edge latchAt.
   function automatic logic expTxBit(input int r, input int latchAt, input logic [7:0] b);
      if (r < latchAt)           return 1'b1;
      if (r < latchAt + CPB)     return 1'b0;
      if (r < latchAt + 9 * CPB) return b[3'((r - latchAt - CPB) / CPB)];
      return 1'b1;
   endfunction

   task automatic alignTick();
      while ((clkSinceRst % CPB) != 0) @(negedge clk);
   endtask

   task automatic applyReset();
      @(negedge clk);
      rst   = 1'b0;
      newd  = 1'b0;
      rx    = 1'b1;
      dintx = 8'h00;
      #1;
      checkVal("reset_tx", tx, 1);
      checkVal("reset_doutrx", doutrx, 0);
      checkVal("reset_donetx", donetx, 0);
      checkVal("reset_donerx", donerx, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic checkTxFrame(input logic [7:0] b, input string tag);
      int txErr   = 0;
      int doneCnt = 0;
      int doneAt  = -1;
      alignTick();
      dintx = b;
      newd  = 1'b1;
      for (int r = 1; r <= 11 * CPB; r++) begin
         @(negedge clk);
         if (tx !== expTxBit(r, CPB, b)) txErr++;
         if (donetx === 1'b1) begin
            doneCnt++;
            doneAt = r;
         end
         if (r == CPB) begin
            newd  = 1'b0;
            dintx = ~b;
         end
      end
      checkVal({tag, "_tx_wave_errs"}, txErr, 0);
      checkVal({tag, "_donetx_count"}, doneCnt, 1);
      checkVal({tag, "_donetx_cycle"}, doneAt, 11 * CPB - 1);
   endtask

   task automatic queueRxByte(input logic [7:0] b);
      rxSyms.push_back(1'b0);
      for (int i = 0; i < 8; i++) rxSyms.push_back(b[i]);
   endtask

   task automatic runRx(input int tailBits, output int pulses, output int lastPulseAt);
      int r = 0;
      pulses      = 0;
      lastPulseAt = -1;
      alignTick();
      foreach (rxSyms[i]) begin
         rx = rxSyms[i];
         repeat (CPB) begin
            @(negedge clk);
            r++;
            if (donerx === 1'b1) begin
               pulses++;
               lastPulseAt = r;
               rxGot.push_back(doutrx);
            end
         end
      end
      rx = 1'b1;
      repeat (tailBits * CPB) begin
         @(negedge clk);
         r++;
         if (donerx === 1'b1) begin
            pulses++;
            lastPulseAt = r;
            rxGot.push_back(doutrx);
         end
      end
   endtask

   initial begin
      logic [7:0] txBytes[10];
      logic [7:0] rxBytes[10];
      logic [7:0] got;
      logic [7:0] drByte;
      int         k, fStart, c, rel, j, frameErr, doneCnt;
      int         pulses, pulseAt, txErr, dtCnt, dtAt, drCnt, drAt, lowCnt;

      applyReset();

      $display("[TB] single frame 0xA5");
      checkTxFrame(8'hA5, "tx_a5");

      $display("[TB] ten back-to-back TX frames");
      for (int i = 0; i < 10; i++) txBytes[i] = 8'($urandom);
      alignTick();
      dintx    = txBytes[0];
      newd     = 1'b1;
      k        = 0;
      fStart   = -1;
      c        = 0;
      frameErr = 0;
      doneCnt  = 0;
      got      = 8'h00;
      while (k < 10 && c < 12 * 11 * CPB) begin
         @(negedge clk);
         c++;
         if (donetx === 1'b1) doneCnt++;
         if (fStart < 0) begin
            if (tx === 1'b0) begin
               fStart = c;
               dintx  = ~txBytes[k];
            end
         end else begin
            rel = c - fStart;
            if ((rel % CPB) == CPB / 2) begin
               j = rel / CPB;
               if (j == 0) begin
                  if (tx !== 1'b0) frameErr++;
               end else if (j <= 8) begin
                  got[3'(j - 1)] = tx;
               end else begin
                  if (tx !== 1'b1) frameErr++;
                  checkVal($sformatf("txb2b_byte%0d", k), got, txBytes[k]);
                  k++;
                  fStart = -1;
                  if (k < 10) dintx = txBytes[k];
                  else        newd  = 1'b0;
               end
            end
         end
      end
      repeat (CPB) begin
         @(negedge clk);
         if (donetx === 1'b1) doneCnt++;
      end
      checkVal("txb2b_frames", k, 10);
      checkVal("txb2b_framing_errs", frameErr, 0);
      checkVal("txb2b_donetx_count", doneCnt, 10);

      $display("[TB] receive 0x3C");
      rxSyms.delete();
      rxGot.delete();
      queueRxByte(8'h3C);
      runRx(2, pulses, pulseAt);
      checkVal("rx3c_pulses", pulses, 1);
      checkVal("rx3c_pulse_cycle", pulseAt, 9 * CPB);
      checkVal("rx3c_byte", (rxGot.size() > 0) ? rxGot[0] : 8'hxx, 8'h3C);
      checkVal("rx3c_hold", doutrx, 8'h3C);
      checkVal("rx3c_donerx_low", donerx, 0);

      $display("[TB] ten RX frames without stop bits");
      for (int i = 0; i < 10; i++) rxBytes[i] = 8'($urandom);
      rxBytes[9] = 8'($urandom_range(1, 255));
      rxSyms.delete();
      rxGot.delete();
      for (int i = 0; i < 10; i++) queueRxByte(rxBytes[i]);
      runRx(2, pulses, pulseAt);
      checkVal("rxb2b_pulses", pulses, 10);
      for (int i = 0; i < 10; i++) begin
         checkVal($sformatf("rxb2b_byte%0d", i), (rxGot.size() > i) ? rxGot[i] : 8'hxx, rxBytes[i]);
      end

      $display("[TB] simultaneous TX 0xFF and RX 0x00");
      alignTick();
      checkVal("sim_doutrx_before", doutrx, rxBytes[9]);
      dintx  = 8'hFF;
      newd   = 1'b1;
      rx     = 1'b1;
      txErr  = 0;
      dtCnt  = 0;
      dtAt   = -1;
      drCnt  = 0;
      drAt   = -1;
      drByte = 8'hxx;
      for (int r = 1; r <= 12 * CPB; r++) begin
         @(negedge clk);
         if (tx !== expTxBit(r, CPB, 8'hFF)) txErr++;
         if (donetx === 1'b1) begin
            dtCnt++;
            dtAt = r;
         end
         if (donerx === 1'b1) begin
            drCnt++;
            drAt   = r;
            drByte = doutrx;
         end
         if (r == CPB) begin
            newd = 1'b0;
            rx   = 1'b0;
         end
         if (r == 10 * CPB) rx = 1'b1;
      end
      checkVal("sim_tx_wave_errs", txErr, 0);
      checkVal("sim_donetx_count", dtCnt, 1);
      checkVal("sim_donetx_cycle", dtAt, 11 * CPB - 1);
      checkVal("sim_donerx_count", drCnt, 1);
      checkVal("sim_donerx_cycle", drAt, 10 * CPB);
      checkVal("sim_rx_byte", drByte, 8'h00);

      $display("[TB] reset during TX data and RX data");
      applyReset();
      dintx = 8'h00;
      newd  = 1'b1;
      rx    = 1'b0;
      while (clkSinceRst < 4 * CPB + 10) @(negedge clk);
      checkVal("abort_tx_in_data", tx, 0);
      #2 rst = 1'b0;
      #1;
      checkVal("abort_tx_immediate", tx, 1);
      checkVal("abort_donetx", donetx, 0);
      checkVal("abort_donerx", donerx, 0);
      checkVal("abort_doutrx", doutrx, 0);
      newd = 1'b0;
      rx   = 1'b1;
      repeat (2) @(negedge clk);
      rst     = 1'b1;
      dtCnt   = 0;
      drCnt   = 0;
      lowCnt  = 0;
      for (int r = 1; r <= 12 * CPB; r++) begin
         @(negedge clk);
         if (donetx === 1'b1) dtCnt++;
         if (donerx === 1'b1) drCnt++;
         if (tx !== 1'b1) lowCnt++;
      end
      checkVal("abort_no_donetx_after", dtCnt, 0);
      checkVal("abort_no_donerx_after", drCnt, 0);
      checkVal("abort_tx_idle_after", lowCnt, 0);
      checkVal("abort_doutrx_after", doutrx, 0);
      checkTxFrame(8'($urandom), "tx_after_abort");

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end

endmodule
